// File: rtl/branch_ctrl.sv
// branch_ctrl -- RISC-V conditional branch evaluator with a 3-state
// request/response FSM (IDLE -> EVAL -> RESP).
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid / req_ready     request handshake (ready only in IDLE)
//   funct3                    branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   rs1_data, rs2_data        compare operands
//   pc, imm                   branch PC and sign-extended offset
//   resp_valid / resp_ready   response handshake (valid only in RESP)
//   taken, target, illegal    result, held until the next result
//   br_count, taken_count     saturating statistics counters
//
// Optional feature: define BRANCH_CTRL_STATS_EN to add the statistics
// counters and their ports.
module branch_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic             illegal
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
`endif
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;

  state_e          state_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q;
  logic            taken_q, illegal_q;
  logic [XLEN-1:0] target_q;

  logic            taken_d, illegal_d;
  logic [XLEN-1:0] target_d;
  logic            eq, lts, ltu;

  // Evaluation works only on captured operands, so the request bus is
  // free to change once the request has been accepted.
  always_comb begin
    eq        = (rs1_q == rs2_q);
    lts       = ($signed(rs1_q) < $signed(rs2_q));
    ltu       = (rs1_q < rs2_q);
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (f3_q)
      3'b000:  taken_d = eq;
      3'b001:  taken_d = !eq;
      3'b100:  taken_d = lts;
      3'b101:  taken_d = !lts;
      3'b110:  taken_d = ltu;
      3'b111:  taken_d = !ltu;
      default: illegal_d = 1'b1;
    endcase
    // Both sums wrap modulo 2^XLEN.
    target_d = taken_d ? (pc_q + imm_q) : (pc_q + XLEN'(4));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      f3_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      target_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          f3_q    <= funct3;
          rs1_q   <= rs1_data;
          rs2_q   <= rs2_data;
          pc_q    <= pc;
          imm_q   <= imm;
          state_q <= EVAL;
        end
        EVAL: begin
          taken_q   <= taken_d;
          illegal_q <= illegal_d;
          target_q  <= target_d;
          state_q   <= RESP;
        end
        RESP: if (resp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign taken      = taken_q;
  assign target     = target_q;
  assign illegal    = illegal_q;

`ifdef BRANCH_CTRL_STATS_EN
  logic [CNT_W-1:0] br_cnt_q, tk_cnt_q;
  logic             resp_hs;

  assign resp_hs = (state_q == RESP) && resp_ready;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else if (resp_hs) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (taken_q && (tk_cnt_q != '1))
        tk_cnt_q <= tk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign br_count    = br_cnt_q;
  assign taken_count = tk_cnt_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: table-driven vectors with a
// response scoreboard, plus hand-written stall, reset-abort and counter
// saturation sequences.
module tb_branch_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       funct3 = '0;
  logic [XLEN-1:0]  rs1_data = '0, rs2_data = '0, pc = '0, imm = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic             illegal;
`ifdef BRANCH_CTRL_STATS_EN
  logic [CNT_W-1:0] br_count, taken_count;
`endif

  branch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pc(pc), .imm(imm),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .taken(taken), .target(target), .illegal(illegal)
`ifdef BRANCH_CTRL_STATS_EN
    , .br_count(br_count), .taken_count(taken_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int              id;
    logic [2:0]      f3;
    logic [XLEN-1:0] rs1, rs2, pc, imm;
    logic            exp_taken;
    logic [XLEN-1:0] exp_target;
    logic            exp_illegal;
  } vec_t;

  vec_t tbl[12];
  vec_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   exp_br = 0;
  int   exp_tk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every response at the handshake.
  always @(negedge clk) begin
    if (rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_resp: got taken=%0b target=%0h want none", taken, target);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk($sformatf("resp_vec%0d", e.id), {30'd0, taken, illegal, target},
            {30'd0, e.exp_taken, e.exp_illegal, e.exp_target});
      end
    end
  end

  function automatic vec_t mk(int id, logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                              logic [31:0] p, logic [31:0] i, logic t, logic [31:0] tg, logic il);
    vec_t v;
    v.id = id; v.f3 = f3; v.rs1 = a; v.rs2 = b; v.pc = p; v.imm = i;
    v.exp_taken = t; v.exp_target = tg; v.exp_illegal = il;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    funct3 = v.f3; rs1_data = v.rs1; rs2_data = v.rs2; pc = v.pc; imm = v.imm;
    req_valid = 1'b1;
  endtask

  task automatic track_stats(input vec_t v);
    if (exp_br < (1 << CNT_W) - 1) exp_br++;
    if (v.exp_taken && exp_tk < (1 << CNT_W) - 1) exp_tk++;
  endtask

  // One request with resp_ready held high; checks the per-cycle sequence.
  task automatic send(input vec_t v);
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #2; n++; end
    if (!req_ready) chk("wait_ready_timeout", 0, 1);
    resp_ready = 1'b1;
    drive(v);
    exp_q.push_back(v);
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("eval_hs_vec%0d", v.id), {req_ready, resp_valid}, 2'b00);
    @(negedge clk);
    chk($sformatf("latency_vec%0d", v.id), resp_valid, 1'b1);
    @(posedge clk); #2;
    track_stats(v);
    @(negedge clk);
    chk($sformatf("resp_drop_vec%0d", v.id), {req_ready, resp_valid}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(0,  3'b000, 32'h5,        32'h5,        32'h100,      32'h20,       1, 32'h120,      0);
    tbl[1]  = mk(1,  3'b000, 32'h5,        32'h6,        32'h100,      32'h20,       0, 32'h104,      0);
    tbl[2]  = mk(2,  3'b001, 32'h5,        32'h6,        32'h200,      32'hFFFF_FFF0, 1, 32'h1F0,     0);
    tbl[3]  = mk(3,  3'b100, 32'hFFFF_FFFF, 32'h1,       32'h300,      32'h40,       1, 32'h340,      0);
    tbl[4]  = mk(4,  3'b110, 32'hFFFF_FFFF, 32'h1,       32'h300,      32'h40,       0, 32'h304,      0);
    tbl[5]  = mk(5,  3'b101, 32'h7,        32'h7,        32'hFFFF_FFF0, 32'h20,      1, 32'h10,       0);
    tbl[6]  = mk(6,  3'b111, 32'h1,        32'hFFFF_FFFF, 32'h400,     32'h8,        0, 32'h404,      0);
    tbl[7]  = mk(7,  3'b011, 32'h9,        32'h9,        32'h500,      32'h80,       0, 32'h504,      1);
    tbl[8]  = mk(8,  3'b010, 32'h1,        32'h2,        32'hFFFF_FFFC, 32'h0,       0, 32'h0,        1);
    tbl[9]  = mk(9,  3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h600,    32'h10,       0, 32'h604,      0);
    tbl[10] = mk(10, 3'b110, 32'h7FFF_FFFF, 32'h8000_0000, 32'h600,    32'h10,       1, 32'h610,      0);
    tbl[11] = mk(11, 3'b111, 32'h5,        32'h5,        32'h700,      32'hC,        1, 32'h70C,      0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_hs", {req_ready, resp_valid}, 2'b10);
    chk("reset_result", {31'd0, taken, illegal, target}, 64'd0);
`ifdef BRANCH_CTRL_STATS_EN
    chk("reset_counters", {br_count, taken_count}, '0);
`endif
    rst = 1'b1;

    // Table vectors; first one is accepted on the first edge after reset.
    foreach (tbl[i]) begin
      send(tbl[i]);
`ifdef BRANCH_CTRL_STATS_EN
      chk($sformatf("br_count_vec%0d", i), br_count, exp_br[CNT_W-1:0]);
      chk($sformatf("taken_count_vec%0d", i), taken_count, exp_tk[CNT_W-1:0]);
`endif
    end

    // Back-pressure: hold resp_ready low while a new request waits.
    @(posedge clk); #2;
    resp_ready = 1'b0;
    drive(tbl[2]);
    exp_q.push_back(tbl[2]);
    @(posedge clk); #2;
    drive(tbl[11]);
    @(negedge clk);
    @(negedge clk);
    chk("stall_enter_resp", resp_valid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall_hold_c%0d", c), {req_ready, resp_valid, taken, illegal, target},
          {2'b01, 1'b1, 1'b0, 32'h1F0});
    end
    @(posedge clk); #2;
    resp_ready = 1'b1;
    @(posedge clk);
    exp_q.push_back(tbl[11]);
    track_stats(tbl[2]);
    #2;
    @(negedge clk);
    chk("stall_release_idle", {req_ready, resp_valid}, 2'b10);
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(negedge clk);
    chk("stall_new_eval", {req_ready, resp_valid}, 2'b00);
    @(negedge clk);
    chk("stall_new_resp", resp_valid, 1'b1);
    @(posedge clk); #2;
    track_stats(tbl[11]);
    @(negedge clk);
`ifdef BRANCH_CTRL_STATS_EN
    chk("stall_br_count", br_count, exp_br[CNT_W-1:0]);
    chk("stall_taken_count", taken_count, exp_tk[CNT_W-1:0]);
`endif

    // Reset asserted in EVAL aborts the request without a response.
    @(posedge clk); #2;
    drive(tbl[0]);
    @(posedge clk); #2;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_async", {req_ready, resp_valid}, 2'b10);
    chk("abort_result", {31'd0, taken, illegal, target}, 64'd0);
`ifdef BRANCH_CTRL_STATS_EN
    chk("abort_counters", {br_count, taken_count}, '0);
`endif
    repeat (2) @(negedge clk);
    chk("abort_no_resp", resp_valid, 1'b0);
    rst = 1'b1;
    exp_br = 0;
    exp_tk = 0;
    send(tbl[7]);

`ifdef BRANCH_CTRL_STATS_EN
    chk("post_abort_br", br_count, 1);
    chk("post_abort_taken", taken_count, 0);
    // Saturation: 2^CNT_W+3 taken BEQ requests on top of a fresh reset.
    @(posedge clk); #2;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    for (int k = 0; k < (1 << CNT_W) + 3; k++)
      send(mk(100 + k, 3'b000, k, k, 32'h1000, 32'h4, 1, 32'h1004, 0));
    chk("sat_br_count", br_count, {CNT_W{1'b1}});
    chk("sat_taken_count", taken_count, {CNT_W{1'b1}});
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
